// File: rtl/alu_pipe_v3.sv
// Two-stage ALU pipeline with a tick-based processing rate divider.
// S1 holds the accepted operands/opcode; S2 holds the registered result and flags.
module alu_pipe_v3 #(
  parameter int unsigned N_BITS = 32,
  localparam int unsigned SH_BITS = $clog2(N_BITS)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [1:0]        i_sel_div,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_operation,
  input  logic [N_BITS-1:0] i_data_a,
  input  logic [N_BITS-1:0] i_data_b,
  output logic [N_BITS-1:0] o_data,
  output logic [3:0]        o_flags,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_tick
);

  typedef enum logic [2:0] {
    OP_XOR = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } op_e;

  logic [2:0]        div_cnt;
  logic [2:0]        div_mask;
  logic              tick;
  logic              s2_load;
  logic              in_fire;

  logic              s1_valid;
  op_e               s1_op;
  logic [N_BITS-1:0] s1_a;
  logic [N_BITS-1:0] s1_b;

  logic [N_BITS-1:0] alu_res;
  logic [N_BITS:0]   alu_sum;
  logic              alu_c;
  logic              alu_v;
  logic [SH_BITS-1:0] shamt;

  // Rate divider: a tick every 1, 2, 4 or 8 cycles, no derived clocks.
  always_comb begin
    div_mask = 3'b000;
    case (i_sel_div)
      2'b00:   div_mask = 3'b000;
      2'b01:   div_mask = 3'b001;
      2'b10:   div_mask = 3'b011;
      default: div_mask = 3'b111;
    endcase
  end

  assign tick    = ((div_cnt & div_mask) == 3'b000);
  assign o_tick  = tick & i_enable;
  assign s2_load = tick & i_enable & (~o_valid | i_ready);
  assign o_ready = ~i_reset & tick & i_enable & (~s1_valid | s2_load);
  assign in_fire = i_valid & o_ready;
  assign shamt   = s1_b[SH_BITS-1:0];

  // ALU on the S1 contents; carry/overflow only meaningful for ADD/SUB.
  always_comb begin
    alu_res = '0;
    alu_sum = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (s1_op)
      OP_XOR: alu_res = s1_a ^ s1_b;
      OP_AND: alu_res = s1_a & s1_b;
      OP_OR:  alu_res = s1_a | s1_b;
      OP_ADD: begin
        alu_sum = {1'b0, s1_a} + {1'b0, s1_b};
        alu_res = alu_sum[N_BITS-1:0];
        alu_c   = alu_sum[N_BITS];
        alu_v   = (s1_a[N_BITS-1] == s1_b[N_BITS-1]) && (alu_res[N_BITS-1] != s1_a[N_BITS-1]);
      end
      OP_SUB: begin
        alu_sum = {1'b0, s1_a} - {1'b0, s1_b};
        alu_res = alu_sum[N_BITS-1:0];
        alu_c   = alu_sum[N_BITS];
        alu_v   = (s1_a[N_BITS-1] != s1_b[N_BITS-1]) && (alu_res[N_BITS-1] != s1_a[N_BITS-1]);
      end
      OP_SLL: alu_res = s1_a << shamt;
      OP_SRL: alu_res = s1_a >> shamt;
      OP_SRA: alu_res = N_BITS'($signed(s1_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Free-running divider counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) div_cnt <= 3'd0;
    else         div_cnt <= div_cnt + 3'd1;
  end

  // Stage 1: operand capture.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_XOR;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= op_e'(i_operation);
      s1_a     <= i_data_a;
      s1_b     <= i_data_b;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register; downstream may consume on any cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_flags <= 4'b0000;
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_data  <= alu_res;
        o_flags <= {alu_res[N_BITS-1], (alu_res == '0), alu_c, alu_v};
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
